// File: rtl/bus_rr_arbiter.sv
// Four-master round-robin arbiter for the shared system bus.
// Active-low requests in, one active-low registered grant out. A one-cycle
// turnaround separates owners, and an unlocked owner is preempted after
// MAX_HOLD cycles when another master is waiting.
module bus_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m0_lock_,
  input  logic       m1_lock_,
  input  logic       m2_lock_,
  input  logic       m3_lock_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       busy
);

  localparam int unsigned NUM_M = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_HOLD - 1);

  // Reject tenure limits the counter cannot represent.
  if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_param
    $error("bus_rr_arbiter: MAX_HOLD out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_M-1:0]   grnt_n_q, grnt_n_d;
  logic               busy_q, busy_d;

  // Active-high views of the bus request and lock pins.
  logic [NUM_M-1:0]   req_c;
  logic [NUM_M-1:0]   lock_c;
  logic [NUM_M-1:0]   own_mask_c;
  logic [IDX_W-1:0]   win_c;
  logic               any_req_c;
  logic               own_req_c;
  logic               own_lock_c;
  logic               others_c;
  logic               release_c;
  logic               preempt_c;

  assign req_c  = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign lock_c = ~{m3_lock_, m2_lock_, m1_lock_, m0_lock_};

  // Round-robin pick: scan last+1 .. last+4 (wrapping), first requester wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx       = '0;
    win_c     = '0;
    any_req_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_M; i++) begin
      idx = last_q + IDX_W'(i);
      if (!any_req_c && req_c[idx]) begin
        win_c     = idx;
        any_req_c = 1'b1;
      end
    end
  end

  // Owner-side conditions: release, waiting competitors and tenure expiry.
  always_comb begin
    own_mask_c = NUM_M'(1) << owner_q;
    own_req_c  = req_c[owner_q];
    own_lock_c = lock_c[owner_q];
    others_c   = |(req_c & ~own_mask_c);
    release_c  = !own_req_c;
    preempt_c  = (cnt_q == CNT_SAT) && others_c && !own_lock_c;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_c) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (release_c || preempt_c) state_d = S_TURN;
      end
      S_TURN: begin
        state_d = any_req_c ? S_GRANT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and datapath next values, keyed on the state transition taken.
  always_comb begin
    grnt_n_d = grnt_n_q;
    busy_d   = busy_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (state_q != S_GRANT && state_d == S_GRANT) begin
      grnt_n_d = ~(NUM_M'(1) << win_c);
      busy_d   = 1'b1;
      owner_d  = win_c;
      last_d   = win_c;
      cnt_d    = '0;
    end else if (state_q == S_GRANT && state_d == S_GRANT) begin
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      grnt_n_d = '1;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end
  end

  // Registered grant, owner, pointer and tenure counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grnt_n_q <= '1;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      last_q   <= IDX_W'(NUM_M - 1);
      cnt_q    <= '0;
    end else begin
      grnt_n_q <= grnt_n_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m0_grnt_ = grnt_n_q[0];
  assign m1_grnt_ = grnt_n_q[1];
  assign m2_grnt_ = grnt_n_q[2];
  assign m3_grnt_ = grnt_n_q[3];
  assign owner    = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed and random bench for the four-master round-robin bus arbiter.
module tb_bus_rr_arbiter;

  localparam int unsigned MAX_HOLD = 16;
  localparam int unsigned WAIT_MAX = 3 * (MAX_HOLD + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_n;
  logic [3:0] lock_n;
  logic [3:0] gn;
  logic [1:0] owner;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst_v;
    logic [3:0] req_v;
    logic [3:0] lock_v;
    logic [3:0] exp_gn;
    logic       exp_busy;
    logic       chk_own;
    logic [1:0] exp_own;
  } vec_t;

  vec_t vq[$];
  int   waits [4];

  always #5 clk = ~clk;

  bus_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req_  (req_n[0]),
    .m1_req_  (req_n[1]),
    .m2_req_  (req_n[2]),
    .m3_req_  (req_n[3]),
    .m0_lock_ (lock_n[0]),
    .m1_lock_ (lock_n[1]),
    .m2_lock_ (lock_n[2]),
    .m3_lock_ (lock_n[3]),
    .m0_grnt_ (gn[0]),
    .m1_grnt_ (gn[1]),
    .m2_grnt_ (gn[2]),
    .m3_grnt_ (gn[3]),
    .owner    (owner),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gv(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  function automatic vec_t v(input logic r, input logic [3:0] rq, input logic [3:0] g,
                             input logic b, input logic c, input logic [1:0] o);
    vec_t t;
    t.rst_v = r; t.req_v = rq; t.lock_v = 4'hF;
    t.exp_gn = g; t.exp_busy = b; t.chk_own = c; t.exp_own = o;
    return t;
  endfunction

  // Expect master k to hold the bus.
  task automatic check_owner(input string name, input int k);
    check({name, "_gnt"}, 32'(gn), 32'(gv(k)));
    check({name, "_busy"}, 32'(busy), 32'd1);
    check({name, "_own"}, 32'(owner), 32'(k));
  endtask

  task automatic check_free(input string name);
    check({name, "_gnt"}, 32'(gn), 32'hF);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Drop all requests and let the arbiter settle back to IDLE.
  task automatic idle_out(input string name);
    req_n = 4'hF; lock_n = 4'hF;
    step(); check_free({name, "_rel"});
    step(); check_free({name, "_idle"});
  endtask

  task automatic check_inv();
    logic [3:0] g;
    g = ~gn;
    check("inv_onehot", 32'($onehot0(g)), 32'd1);
    check("inv_busy", 32'(busy), 32'(|g));
    if (|g) check("inv_owner", 32'(g[owner]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_n = 4'hF; lock_n = 4'hF;

    // Single-cycle reset, then m1 alone owns the bus for 100 cycles.
    step();
    check_free("reset");
    check("reset_own", 32'(owner), 32'd0);
    rst = 1'b1;
    step(); check_free("post_reset");
    req_n = 4'b1101;
    for (int c = 0; c < 100; c++) begin
      step(); check_owner("m1_hold", 1);
    end
    idle_out("m1_hold");

    // Single-cycle vectors: round-robin order, turnaround, reset pointer.
    vq.push_back(v(1'b0, 4'hF,    4'hF,    1'b0, 1'b1, 2'd0));
    vq.push_back(v(1'b1, 4'hF,    4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b1101, 4'b1101, 1'b1, 1'b1, 2'd1));
    vq.push_back(v(1'b1, 4'b1101, 4'b1101, 1'b1, 1'b1, 2'd1));
    vq.push_back(v(1'b1, 4'b1010, 4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b1010, 4'b1011, 1'b1, 1'b1, 2'd2));
    vq.push_back(v(1'b1, 4'b1110, 4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b1110, 4'b1110, 1'b1, 1'b1, 2'd0));
    vq.push_back(v(1'b1, 4'hF,    4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'hF,    4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b0, 4'hF,    4'hF,    1'b0, 1'b1, 2'd0));
    vq.push_back(v(1'b1, 4'b1010, 4'b1110, 1'b1, 1'b1, 2'd0));
    vq.push_back(v(1'b1, 4'b1010, 4'b1110, 1'b1, 1'b1, 2'd0));
    vq.push_back(v(1'b1, 4'b1011, 4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b1011, 4'b1011, 1'b1, 1'b1, 2'd2));
    vq.push_back(v(1'b1, 4'b0101, 4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b0101, 4'b0111, 1'b1, 1'b1, 2'd3));
    vq.push_back(v(1'b1, 4'b1101, 4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b1101, 4'b1101, 1'b1, 1'b1, 2'd1));
    vq.push_back(v(1'b1, 4'b0101, 4'b1101, 1'b1, 1'b1, 2'd1));
    vq.push_back(v(1'b1, 4'b0111, 4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'b0101, 4'b0111, 1'b1, 1'b1, 2'd3));
    vq.push_back(v(1'b1, 4'hF,    4'hF,    1'b0, 1'b0, 2'd0));
    vq.push_back(v(1'b1, 4'hF,    4'hF,    1'b0, 1'b0, 2'd0));

    foreach (vq[i]) begin
      rst = vq[i].rst_v; req_n = vq[i].req_v; lock_n = vq[i].lock_v;
      step();
      check($sformatf("vec%0d_gnt", i), 32'(gn), 32'(vq[i].exp_gn));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].exp_busy));
      if (vq[i].chk_own) check($sformatf("vec%0d_own", i), 32'(owner), 32'(vq[i].exp_own));
    end

    // m0 and m3 both hold requests: 16-cycle tenures with one dead cycle between.
    req_n = 4'b0110;
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < int'(MAX_HOLD); c++) begin
        step(); check_owner($sformatf("tenure%0d", t), (t % 2 == 0) ? 0 : 3);
      end
      step(); check_free($sformatf("tenure%0d_dead", t));
    end
    idle_out("tenure");

    // Locked m2 is never preempted; dropping lock hands over to m1.
    req_n = 4'b1011; lock_n = 4'b1011;
    step(); check_owner("lock_start", 2);
    req_n = 4'b1001;
    for (int c = 0; c < 40; c++) begin
      step(); check_owner("locked", 2);
    end
    lock_n = 4'hF;
    step(); check_free("unlock_turn");
    step(); check_owner("unlock_m1", 1);
    // A non-owner lock does not protect m1 from preemption by m2.
    lock_n = 4'b1011;
    for (int c = 1; c < int'(MAX_HOLD); c++) begin
      step(); check_owner("nonown_lock", 1);
    end
    step(); check_free("nonown_lock_turn");
    step(); check_owner("nonown_lock_m2", 2);
    idle_out("lock");

    // Asynchronous reset mid-transfer drops the grant at once.
    req_n = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      step(); check_owner("m3_xfer", 3);
    end
    #3 rst = 1'b0;
    #1 check_free("async_rst");
    step(); check_free("rst_held");
    check("rst_held_own", 32'(owner), 32'd0);
    #3 rst = 1'b1;
    step(); check_owner("m3_regrant", 3);
    // A sole requester keeps the bus past MAX_HOLD.
    for (int c = 0; c < 20; c++) begin
      step(); check_owner("sole", 3);
    end
    idle_out("sole");

    // A request pulse between edges is never seen.
    #2 req_n = 4'b1110;
    #2 req_n = 4'hF;
    step(); check_free("glitch");

    // Random requests and locks: structural invariants.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) req_n[i] = ~req_n[i];
        lock_n[i] = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      end
      step(); check_inv();
    end

    // Random requests with locks high: invariants plus bounded waiting.
    lock_n = 4'hF;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    for (int c = 0; c < 7000; c++) begin
      int worst;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 15) == 0) req_n[i] = ~req_n[i];
      end
      step(); check_inv();
      worst = 0;
      for (int i = 0; i < 4; i++) begin
        if (!req_n[i] && gn[i]) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > worst) worst = waits[i];
      end
      check("wait_bound", 32'(worst <= int'(WAIT_MAX)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Four-master round-robin arbiter for the shared system bus. It takes active-low bus requests from masters m0–m3 and drives exactly one active-low grant at a time. It enforces a one-cycle turnaround between owners and a bounded tenure, so a master holding the bus cannot starve others unless it asserts lock. The arbiter sits beside the bus mux and its grant outputs drive the bus's master select.

## Interface
- MAX_HOLD, default 16: maximum cycles an unlocked owner keeps the bus while another master is requesting; legal range 2..2^CNT_W.
- CNT_W, default 5: width of the tenure counter.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req_ .. m3_req_  in  1 each  bus request, active-low, level-held for the whole transfer.
- m0_lock_ .. m3_lock_  in  1 each  bus lock, active-low; honoured only for the current owner.
- m0_grnt_ .. m3_grnt_  out  1 each  bus grant, active-low, registered; at most one low at any time.
- owner  out  2  index of the current owner; valid only while busy=1.
- busy  out  1  high while any grant is asserted.

## Operation
- Reset values while rst=0:
  - all mX_grnt_=1, busy=0, owner=0.
  - state=IDLE, tenure counter=0.
  - round-robin pointer last=3, so m0 has highest priority after reset.
- Arbitration order: last+1, last+2, last+3, last, modulo 4. The first requester in this order with mX_req_=0 wins. On a grant, last is set to the winner.
- IDLE:
  - No grant asserted.
  - If any request is low at the edge, go to GRANT with the winner's grant low, owner=winner, busy=1 and counter=0.
- GRANT:
  - Counter increments by 1 each cycle and saturates at MAX_HOLD-1.
  - Release: if the owner's mX_req_=1 at the edge, go to TURN. All grants go high and busy=0.
  - Preempt: if counter==MAX_HOLD-1, another master's request is low and the owner's lock_=1, go to TURN as for release.
  - With the owner's lock_=0, preemption is suppressed and the counter stays saturated. Releasing lock while saturated with another requester pending preempts at the next edge.
- TURN (exactly 1 cycle, no grant asserted):
  - If any request is low, go to GRANT using the round-robin order. The previous owner, as last, has lowest priority.
  - Otherwise go to IDLE.
- Requests that go low and return high between edges are never seen. Nothing is latched.
- lock_ of non-owners is ignored.

## Timing
- Request to grant from IDLE: request sampled low at edge k; grant low after edge k, i.e. 1 cycle of latency.
- Release to next grant: owner's request sampled high at edge k; all grants high after edge k; new grant low after edge k+1, so one dead cycle.
- Tenure: an unlocked owner holds the grant for at most MAX_HOLD cycles while others wait, then is preempted. A sole requester is never preempted.
- Simultaneous requests: resolved strictly by round-robin order, with no fixed priority beyond the post-reset pointer.
- A preempted owner still requesting re-competes in TURN with lowest priority.
- Asynchronous reset mid-transfer: grants go high immediately, not at the next edge. After rst rises, arbitration resumes from IDLE with last=3.
- Invariant: grant vector one-hot or all high in every cycle; busy equals the OR of the asserted grants.

## Test plan
- Reset with rst=0 for 1 cycle, all requests high, then rst=1 and m1_req_=0 one cycle later. Required: m1_grnt_=0 one edge after the request, owner=1, busy=1, other grants high for 100 cycles.
- m0_req_ and m2_req_ low together from IDLE after reset. Required: m0 granted first. When m0 releases, one cycle with all grants high, then m2 granted, with owner stepping 0→2.
- m0 and m3 both continuously requesting, locks high, MAX_HOLD=16. Required: grant alternates m0, m3, m0… Each tenure lasts 16 cycles, separated by 1 dead cycle.
- m2 owner with m2_lock_=0 and m1 requesting for 40 cycles. Required: no preemption. After m2_lock_ rises, m2_grnt_ goes high on the next edge and m1_grnt_ goes low one edge later.
- rst driven low while m3 is granted mid-transfer. Required: m3_grnt_=1 and busy=0 immediately. After reset with m3 still requesting, m3 is regranted 1 cycle after rst rises.
- Random request and lock stimulus for 10k cycles. Required: the one-hot invariant and busy consistency hold every cycle, and no requester waits more than 3·(MAX_HOLD+1) cycles while all locks are high.
